// File: rtl/pcie_tlp_pkg.sv
// Shared PCIe TLP field encodings and encoder state type.
package pcie_tlp_pkg;

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [4:0] TYPE_CPL       = 5'b01010;
    localparam logic [2:0] CPL_SC         = 3'b000;
    localparam logic [2:0] CPL_UR         = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } cpl_state_e;

endpackage

// File: rtl/pcie_be_lower_addr.sv
// First-set-bit encoder of the first-DW byte enables; all-zero enables map to offset 0.
module pcie_be_lower_addr
    import pcie_tlp_pkg::*;
(
    input  logic [3:0] be_i,
    output logic [1:0] off_o
);

    always_comb begin
        off_o = 2'd0;
        if (be_i[0])      off_o = 2'd0;
        else if (be_i[1]) off_o = 2'd1;
        else if (be_i[2]) off_o = 2'd2;
        else if (be_i[3]) off_o = 2'd3;
    end

endmodule

// File: rtl/pcie_tlp_cpl_enc.sv
// Completion TLP encoder: turns one read-completion request into a two-beat 3DW Cpl/CplD.
//
// state    | meaning
// IDLE     | cpl_ready high, waiting for a request
// BEAT0    | presenting {DW1,DW0} with sop
// BEAT1    | presenting {DATA,DW2} with eop
module pcie_tlp_cpl_enc
    import pcie_tlp_pkg::*;
#(
    parameter logic [15:0] COMPLETER_ID = 16'h0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpl_valid,
    output logic        cpl_ready,
    input  logic        cpl_ur,
    input  logic [15:0] cpl_requester_id,
    input  logic [7:0]  cpl_tag,
    input  logic [15:0] cpl_addr,
    input  logic [3:0]  cpl_be,
    input  logic [11:0] cpl_byte_cnt,
    input  logic [31:0] cpl_data,
    output logic [63:0] tx_data,
    output logic [1:0]  tx_keep,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] cpl_count,
    output logic        busy
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_BEAT0 = ST_BEAT0;
    localparam logic [1:0] S_BEAT1 = ST_BEAT1;

    logic [1:0]  state_q, state_d;
    logic        rdy_q;
    logic        ur_q;
    logic [15:0] req_id_q;
    logic [7:0]  tag_q;
    logic [4:0]  addr_q;
    logic [3:0]  be_q;
    logic [11:0] byte_cnt_q;
    logic [31:0] data_q;
    logic [15:0] count_q, count_d;
    logic        accept;
    logic [1:0]  off;
    logic [31:0] dw0, dw1, dw2;
    logic        unused_addr;

    // Only addr[6:2] feeds lower_addr; the low two bits come from the byte enables.
    assign unused_addr = ^{cpl_addr[15:7], cpl_addr[1:0]};

    // Handshake qualifies on the registered ready so nothing is taken in the cycle after reset.
    assign accept = cpl_valid & rdy_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_BEAT0;
            S_BEAT0: if (tx_ready) state_d = S_BEAT1;
            S_BEAT1: begin
                if (tx_ready) begin
                    state_d = S_IDLE;
                    count_d = count_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rdy_q      <= 1'b0;
            count_q    <= 16'd0;
            ur_q       <= 1'b0;
            req_id_q   <= 16'd0;
            tag_q      <= 8'd0;
            addr_q     <= 5'd0;
            be_q       <= 4'd0;
            byte_cnt_q <= 12'd0;
            data_q     <= 32'd0;
        end else begin
            state_q <= state_d;
            rdy_q   <= (state_d == S_IDLE);
            count_q <= count_d;
            if (accept) begin
                ur_q       <= cpl_ur;
                req_id_q   <= cpl_requester_id;
                tag_q      <= cpl_tag;
                addr_q     <= cpl_addr[6:2];
                be_q       <= cpl_be;
                byte_cnt_q <= cpl_byte_cnt;
                data_q     <= cpl_data;
            end
        end
    end

    pcie_be_lower_addr u_lower_addr (
        .be_i  (be_q),
        .off_o (off)
    );

    always_comb begin
        dw0 = ur_q ? {FMT_3DW_NODATA, TYPE_CPL, 8'h00, 6'b0, 10'd0}
                   : {FMT_3DW_DATA,   TYPE_CPL, 8'h00, 6'b0, 10'd1};
        dw1 = {COMPLETER_ID, (ur_q ? CPL_UR : CPL_SC), 1'b0, byte_cnt_q};
        dw2 = {req_id_q, tag_q, 1'b0, addr_q, off};
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_sop   = 1'b0;
        tx_eop   = 1'b0;
        tx_keep  = 2'b00;
        tx_data  = 64'd0;
        case (state_q)
            S_BEAT0: begin
                tx_valid = 1'b1;
                tx_sop   = 1'b1;
                tx_keep  = 2'b11;
                tx_data  = {dw1, dw0};
            end
            S_BEAT1: begin
                tx_valid = 1'b1;
                tx_eop   = 1'b1;
                tx_keep  = ur_q ? 2'b01 : 2'b11;
                tx_data  = {(ur_q ? 32'd0 : data_q), dw2};
            end
            default: ;
        endcase
    end

    assign cpl_ready = rdy_q;
    assign cpl_count = count_q;
    assign busy      = (state_q != S_IDLE);

endmodule
